// File: rtl/unstep_buffer.sv
// unstep_buffer: per-lane delay lines that realign staggered accumulator lanes so all lanes emerge together.
// Optional lane-alignment monitor is built when UNSTEP_ALIGN_CHECK_EN is defined.
module unstep_buffer #(
  parameter int WORD_WIDTH        = 32,
  parameter int STEPS             = 4,
  parameter int ACCUMULATOR_DELAY = 4,
  parameter int TUSER_WIDTH       = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   aclken,
  input  logic                   is_1x1,
  input  logic                   s_valid [STEPS-1:0],
  input  logic                   s_last  [STEPS-1:0],
  input  logic [WORD_WIDTH-1:0]  s_data  [STEPS-1:0],
  input  logic [TUSER_WIDTH-1:0] s_user  [STEPS-1:0],
  output logic                   m_valid [STEPS-1:0],
  output logic                   m_last  [STEPS-1:0],
  output logic [WORD_WIDTH-1:0]  m_data  [STEPS-1:0],
  output logic [TUSER_WIDTH-1:0] m_user  [STEPS-1:0],
  output logic                   align_err
);

  localparam int A  = ACCUMULATOR_DELAY;
  localparam int BW = WORD_WIDTH + TUSER_WIDTH + 2;

  function automatic int skew(input int i);
    return (i == 0) ? 0 : i * (A - 2) + 1;
  endfunction

  localparam int DMAX = skew(STEPS - 1);
  localparam int CW   = $clog2(DMAX + 2);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(DMAX + 1);

  // Beat packing: {valid, last, data, user} travels as one word so a beat is never split.
  logic [BW-1:0] pre_beat [STEPS-1:0];

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_lane
      localparam int DEPTH = DMAX - skew(gi);
      logic [BW-1:0] in_beat;
      logic [BW-1:0] delayed;

      assign in_beat = {s_valid[gi], s_last[gi], s_data[gi], s_user[gi]};

      if (DEPTH > 0) begin : g_pipe
        logic [BW-1:0] stage_reg [DEPTH];

        always_ff @(posedge aclk) begin
          if (areset) begin
            for (int s = 0; s < DEPTH; s++) stage_reg[s] <= '0;
          end else if (aclken) begin
            stage_reg[0] <= in_beat;
            for (int s = 1; s < DEPTH; s++) stage_reg[s] <= stage_reg[s-1];
          end
        end

        assign delayed = stage_reg[DEPTH-1];
      end else begin : g_bypass
        assign delayed = in_beat;
      end

      assign pre_beat[gi] = is_1x1 ? in_beat : delayed;
    end
  endgenerate

  logic          mode_reg;
  logic [CW-1:0] flush_cnt_reg;
  logic [CW-1:0] flush_cnt_next;
  logic          flushing;

  // Masking keys off the post-edge count so the qualifiers stay low exactly DMAX+1 cycles.
  always_comb begin
    flush_cnt_next = flush_cnt_reg;
    if (is_1x1 != mode_reg) flush_cnt_next = FLUSH_LOAD;
    else if (flush_cnt_reg != '0) flush_cnt_next = flush_cnt_reg - CW'(1);
  end

  assign flushing = (flush_cnt_next != '0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      mode_reg      <= is_1x1;
      flush_cnt_reg <= '0;
      for (int i = 0; i < STEPS; i++) begin
        m_valid[i] <= 1'b0;
        m_last[i]  <= 1'b0;
        m_data[i]  <= '0;
        m_user[i]  <= '0;
      end
    end else if (aclken) begin
      mode_reg      <= is_1x1;
      flush_cnt_reg <= flush_cnt_next;
      for (int i = 0; i < STEPS; i++) begin
        m_valid[i] <= pre_beat[i][BW-1] & ~flushing;
        m_last[i]  <= pre_beat[i][BW-2] & ~flushing;
        m_data[i]  <= pre_beat[i][BW-3 -: WORD_WIDTH];
        m_user[i]  <= pre_beat[i][TUSER_WIDTH-1:0];
      end
    end
  end

`ifdef UNSTEP_ALIGN_CHECK_EN
  logic mismatch;
  logic align_err_reg;

  always_comb begin
    mismatch = 1'b0;
    for (int i = 1; i < STEPS; i++) begin
      if (pre_beat[i][BW-1 -: 2] != pre_beat[0][BW-1 -: 2]) mismatch = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) align_err_reg <= 1'b0;
    else if (aclken && !flushing && mismatch) align_err_reg <= 1'b1;
  end

  assign align_err = align_err_reg;
`else
  assign align_err = 1'b0;
`endif

endmodule
